ablauf_steuerwerk: RTL and testbench

//  Sequences the processor core: fetch, decode, execute, memory, writeback.

---
 rtl/ablauf_steuerwerk_if.sv | 47 ++++
 rtl/ablauf_steuerwerk.sv | 152 +++++++++++++++
 tb/tb_ablauf_steuerwerk.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ablauf_steuerwerk_if.sv
// Handshake and data bundle between the sequencer and the core datapath
// (fetch, decoder flags, ALU, data memory, register file).
interface ablauf_steuerwerk_if #(
  parameter int unsigned ADRESS_BREITE = 32
);
  logic                     Befehlsanfrage;
  logic                     BefehlBereit;
  logic                     DekodierSignal;
  logic                     LoadBefehl;
  logic                     StoreBefehl;
  logic                     UnbedingterSprungBefehl;
  logic                     BedingterSprungBefehl;
  logic                     RelativerSprung;
  logic                     AbsoluterSprung;
  logic                     JALBefehl;
  logic                     Sprungbedingung;
  logic [31:0]              IDaten;
  logic [31:0]              SprungRegisterWert;
  logic [31:0]              BedingungsWert;
  logic                     ALUStart;
  logic                     ALUFertig;
  logic                     SpeicherAnfrage;
  logic                     SpeicherSchreiben;
  logic                     SpeicherBereit;
  logic                     RegisterSchreiben;
  logic [ADRESS_BREITE-1:0] JALRuecksprung;
  logic [ADRESS_BREITE-1:0] PC;
  logic                     Fehler;

  modport master (
    output Befehlsanfrage, DekodierSignal, ALUStart, SpeicherAnfrage,
           SpeicherSchreiben, RegisterSchreiben, JALRuecksprung, PC, Fehler,
    input  BefehlBereit, LoadBefehl, StoreBefehl, UnbedingterSprungBefehl,
           BedingterSprungBefehl, RelativerSprung, AbsoluterSprung, JALBefehl,
           Sprungbedingung, IDaten, SprungRegisterWert, BedingungsWert,
           ALUFertig, SpeicherBereit
  );

  modport slave (
    input  Befehlsanfrage, DekodierSignal, ALUStart, SpeicherAnfrage,
           SpeicherSchreiben, RegisterSchreiben, JALRuecksprung, PC, Fehler,
    output BefehlBereit, LoadBefehl, StoreBefehl, UnbedingterSprungBefehl,
           BedingterSprungBefehl, RelativerSprung, AbsoluterSprung, JALBefehl,
           Sprungbedingung, IDaten, SprungRegisterWert, BedingungsWert,
           ALUFertig, SpeicherBereit
  );
endinterface

// File: rtl/ablauf_steuerwerk.sv
// Core sequencer: fetch, decode, execute, memory, writeback with one
// instruction in flight; owns the PC and a per-handshake timeout.
module ablauf_steuerwerk #(
  parameter int unsigned              ADRESS_BREITE = 32,
  parameter logic [ADRESS_BREITE-1:0] START_ADRESSE = '0,
  parameter int unsigned              WARTE_LIMIT   = 255
) (
  input logic                  Takt,
  input logic                  Reset,
  ablauf_steuerwerk_if.master  bus
);

  localparam int unsigned ZW       = (WARTE_LIMIT < 2) ? 1 : $clog2(WARTE_LIMIT + 1);
  localparam int unsigned LIMIT_M1 = (WARTE_LIMIT == 0) ? 0 : WARTE_LIMIT - 1;

  typedef enum logic [2:0] {
    START, HOLEN, DEKODIEREN, AUSFUEHREN, SPEICHER, ALU_WARTEN, FEHLER
  } zustand_t;

  zustand_t               state_q, state_d;
  logic [ADRESS_BREITE-1:0] pc_q, pc_d;
  logic [ADRESS_BREITE-1:0] link_q, link_d;
  logic [ZW-1:0]          cnt_q, cnt_d;
  logic                   schreiben_q, schreiben_d;
  logic                   alu_start_q, alu_start_d;
  logic                   reg_schreiben_q, reg_schreiben_d;
  logic                   befehlsanfrage_q, dekodier_q, speicher_anfrage_q, fehler_q;

  logic [ADRESS_BREITE-1:0] sprung_ziel;
  logic [ADRESS_BREITE-1:0] pc_plus_imm;
  logic                     verzweigt;
  logic                     limit_erreicht;

  // Jump kind is fully selected by RelativerSprung; the absolute flag is redundant.
  logic unused_flags;
  assign unused_flags = bus.AbsoluterSprung;

  assign pc_plus_imm    = pc_q + ADRESS_BREITE'(bus.IDaten);
  assign sprung_ziel    = bus.RelativerSprung ? pc_plus_imm
                                              : ADRESS_BREITE'(bus.SprungRegisterWert);
  assign verzweigt      = bus.Sprungbedingung ? (bus.BedingungsWert == '0)
                                              : (bus.BedingungsWert != '0);
  assign limit_erreicht = (WARTE_LIMIT != 0) && (cnt_q == ZW'(LIMIT_M1));

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    link_d          = link_q;
    cnt_d           = cnt_q;
    schreiben_d     = schreiben_q;
    alu_start_d     = 1'b0;
    reg_schreiben_d = 1'b0;

    case (state_q)
      START: state_d = HOLEN;
      HOLEN: begin
        if (bus.BefehlBereit)        state_d = DEKODIEREN;
        else if (limit_erreicht)     state_d = FEHLER;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      DEKODIEREN: state_d = AUSFUEHREN;
      AUSFUEHREN: begin
        if (bus.UnbedingterSprungBefehl) begin
          if (bus.JALBefehl) begin
            reg_schreiben_d = 1'b1;
            link_d          = pc_q + 1'b1;
          end
          pc_d    = sprung_ziel;
          state_d = HOLEN;
        end else if (bus.BedingterSprungBefehl) begin
          pc_d    = verzweigt ? pc_plus_imm : pc_q + 1'b1;
          state_d = HOLEN;
        end else if (bus.LoadBefehl || bus.StoreBefehl) begin
          schreiben_d = bus.StoreBefehl;
          state_d     = SPEICHER;
        end else begin
          alu_start_d = 1'b1;
          state_d     = ALU_WARTEN;
        end
      end
      SPEICHER: begin
        if (bus.SpeicherBereit) begin
          reg_schreiben_d = ~schreiben_q;
          schreiben_d     = 1'b0;
          pc_d            = pc_q + 1'b1;
          state_d         = HOLEN;
        end else if (limit_erreicht) begin
          state_d = FEHLER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ALU_WARTEN: begin
        if (bus.ALUFertig) begin
          reg_schreiben_d = 1'b1;
          pc_d            = pc_q + 1'b1;
          state_d         = HOLEN;
        end else if (limit_erreicht) begin
          state_d = FEHLER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FEHLER:  state_d = FEHLER;
      default: state_d = FEHLER;
    endcase

    // Any state change restarts the wait counter, covering every wait-state entry.
    if (state_d != state_q) cnt_d = '0;
    if (state_d == FEHLER)  schreiben_d = 1'b0;
  end

  // Level outputs are registered from the next state so they track the state exactly.
  always_ff @(posedge Takt or posedge Reset) begin
    if (Reset) begin
      state_q            <= START;
      pc_q               <= START_ADRESSE;
      link_q             <= '0;
      cnt_q              <= '0;
      schreiben_q        <= 1'b0;
      alu_start_q        <= 1'b0;
      reg_schreiben_q    <= 1'b0;
      befehlsanfrage_q   <= 1'b0;
      dekodier_q         <= 1'b0;
      speicher_anfrage_q <= 1'b0;
      fehler_q           <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      link_q             <= link_d;
      cnt_q              <= cnt_d;
      schreiben_q        <= schreiben_d;
      alu_start_q        <= alu_start_d;
      reg_schreiben_q    <= reg_schreiben_d;
      befehlsanfrage_q   <= (state_d == HOLEN);
      dekodier_q         <= (state_d == DEKODIEREN);
      speicher_anfrage_q <= (state_d == SPEICHER);
      fehler_q           <= (state_d == FEHLER);
    end
  end

  assign bus.Befehlsanfrage    = befehlsanfrage_q;
  assign bus.DekodierSignal    = dekodier_q;
  assign bus.ALUStart          = alu_start_q;
  assign bus.SpeicherAnfrage   = speicher_anfrage_q;
  assign bus.SpeicherSchreiben = schreiben_q;
  assign bus.RegisterSchreiben = reg_schreiben_q;
  assign bus.JALRuecksprung    = link_q;
  assign bus.PC                = pc_q;
  assign bus.Fehler            = fehler_q;

endmodule

// File: tb/tb_ablauf_steuerwerk.sv
// Self-checking bench for ablauf_steuerwerk: directed scenarios followed by
// random instruction streams against an instruction-level reference model.
module tb_ablauf_steuerwerk;

  localparam int T_ALU = 0, T_LOAD = 1, T_STORE = 2, T_JAL = 3,
                 T_J = 4, T_JREG = 5, T_BEZ = 6, T_BNEZ = 7;

  logic Takt  = 1'b0;
  logic Reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] model_pc;

  ablauf_steuerwerk_if #(.ADRESS_BREITE(32)) bus ();

  ablauf_steuerwerk #(
    .ADRESS_BREITE(32),
    .START_ADRESSE(32'h0),
    .WARTE_LIMIT  (4)
  ) dut (
    .Takt (Takt),
    .Reset(Reset),
    .bus  (bus.master)
  );

  always #5 Takt = ~Takt;

  initial begin
    #300000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Takt);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_flags();
    bus.LoadBefehl              = 1'b0;
    bus.StoreBefehl             = 1'b0;
    bus.UnbedingterSprungBefehl = 1'b0;
    bus.BedingterSprungBefehl   = 1'b0;
    bus.RelativerSprung         = 1'b0;
    bus.AbsoluterSprung         = 1'b0;
    bus.JALBefehl               = 1'b0;
    bus.Sprungbedingung         = 1'b0;
  endtask

  // Runs one instruction from its first fetch cycle to the next fetch cycle.
  task automatic exec_instr(input int typ, input logic [31:0] imm, input logic [31:0] regv,
                            input logic [31:0] condv, input int fd, input int dd);
    logic [31:0] exp_pc;
    logic        exp_rs;
    logic        is_jump, is_branch, is_mem;
    is_jump   = (typ == T_JAL) || (typ == T_J) || (typ == T_JREG);
    is_branch = (typ == T_BEZ) || (typ == T_BNEZ);
    is_mem    = (typ == T_LOAD) || (typ == T_STORE);
    exp_rs    = (typ == T_ALU) || (typ == T_LOAD) || (typ == T_JAL);
    case (typ)
      T_JAL, T_J: exp_pc = model_pc + imm;
      T_JREG:     exp_pc = regv;
      T_BEZ:      exp_pc = (condv == 0) ? model_pc + imm : model_pc + 1;
      T_BNEZ:     exp_pc = (condv != 0) ? model_pc + imm : model_pc + 1;
      default:    exp_pc = model_pc + 1;
    endcase

    chk1("fetch_req", bus.Befehlsanfrage, 1'b1);
    chk32("fetch_pc", bus.PC, model_pc);
    for (int i = 0; i < fd; i++) begin
      bus.BefehlBereit   = 1'b0;
      bus.ALUFertig      = 1'($urandom_range(0, 1));
      bus.SpeicherBereit = 1'($urandom_range(0, 1));
      step();
      chk1("fetch_wait_req", bus.Befehlsanfrage, 1'b1);
      chk1("fetch_wait_dek", bus.DekodierSignal, 1'b0);
    end
    bus.BefehlBereit = 1'b1;
    step();
    bus.BefehlBereit = 1'b0;
    chk1("dek_strobe", bus.DekodierSignal, 1'b1);
    chk1("dek_req_drop", bus.Befehlsanfrage, 1'b0);
    chk1("dek_no_rs", bus.RegisterSchreiben, 1'b0);

    bus.UnbedingterSprungBefehl = is_jump;
    bus.BedingterSprungBefehl   = is_branch || (is_jump && ($urandom_range(0, 1) == 1));
    bus.RelativerSprung         = (typ == T_JAL) || (typ == T_J) ||
                                  (is_branch && ($urandom_range(0, 1) == 1));
    bus.AbsoluterSprung         = (typ == T_JREG);
    bus.JALBefehl               = (typ == T_JAL);
    bus.Sprungbedingung         = (typ == T_BEZ) ? 1'b1 : (typ == T_BNEZ) ? 1'b0
                                                 : 1'($urandom_range(0, 1));
    bus.LoadBefehl  = (typ == T_LOAD)  || ((is_jump || is_branch) && ($urandom_range(0, 1) == 1));
    bus.StoreBefehl = (typ == T_STORE) || ((is_jump || is_branch) && ($urandom_range(0, 1) == 1));
    bus.IDaten             = imm;
    bus.SprungRegisterWert = regv;
    bus.BedingungsWert     = condv;
    bus.ALUFertig          = 1'($urandom_range(0, 1));
    bus.SpeicherBereit     = 1'($urandom_range(0, 1));
    step();
    chk1("exec_dek_low", bus.DekodierSignal, 1'b0);
    chk1("exec_no_alustart", bus.ALUStart, 1'b0);
    bus.ALUFertig      = 1'b0;
    bus.SpeicherBereit = 1'b0;
    step();
    clear_flags();

    if (typ == T_ALU) begin
      chk1("alu_start", bus.ALUStart, 1'b1);
      for (int i = 0; i < dd; i++) begin
        bus.SpeicherBereit = 1'($urandom_range(0, 1));
        step();
        chk1("alu_start_once", bus.ALUStart, 1'b0);
        chk1("alu_wait_no_rs", bus.RegisterSchreiben, 1'b0);
      end
      bus.ALUFertig      = 1'b1;
      bus.SpeicherBereit = 1'b0;
      step();
      bus.ALUFertig = 1'b0;
      chk1("alu_start_low", bus.ALUStart, 1'b0);
    end else if (is_mem) begin
      chk1("mem_req", bus.SpeicherAnfrage, 1'b1);
      chk1("mem_dir", bus.SpeicherSchreiben, typ == T_STORE);
      for (int i = 0; i < dd; i++) begin
        bus.ALUFertig = 1'($urandom_range(0, 1));
        step();
        chk1("mem_wait_req", bus.SpeicherAnfrage, 1'b1);
        chk1("mem_wait_dir", bus.SpeicherSchreiben, typ == T_STORE);
        chk1("mem_wait_no_rs", bus.RegisterSchreiben, 1'b0);
      end
      bus.SpeicherBereit = 1'b1;
      bus.ALUFertig      = 1'b0;
      step();
      bus.SpeicherBereit = 1'b0;
      chk1("mem_req_drop", bus.SpeicherAnfrage, 1'b0);
    end

    chk1("wb_rs", bus.RegisterSchreiben, exp_rs);
    if (typ == T_JAL) chk32("jal_link", bus.JALRuecksprung, model_pc + 1);
    chk32("next_pc", bus.PC, exp_pc);
    chk1("next_fetch", bus.Befehlsanfrage, 1'b1);
    chk1("no_fehler", bus.Fehler, 1'b0);
    model_pc = exp_pc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk32({tag, "_pc"}, bus.PC, 32'h0);
    chk1({tag, "_req"}, bus.Befehlsanfrage, 1'b0);
    chk1({tag, "_dek"}, bus.DekodierSignal, 1'b0);
    chk1({tag, "_alu"}, bus.ALUStart, 1'b0);
    chk1({tag, "_mem"}, bus.SpeicherAnfrage, 1'b0);
    chk1({tag, "_dir"}, bus.SpeicherSchreiben, 1'b0);
    chk1({tag, "_rs"}, bus.RegisterSchreiben, 1'b0);
    chk1({tag, "_fehler"}, bus.Fehler, 1'b0);
  endtask

  initial begin
    bus.BefehlBereit       = 1'b0;
    bus.ALUFertig          = 1'b0;
    bus.SpeicherBereit     = 1'b0;
    bus.IDaten             = '0;
    bus.SprungRegisterWert = '0;
    bus.BedingungsWert     = '0;
    clear_flags();

    // Power-on reset
    #1 Reset = 1'b1;
    #1;
    check_reset_outputs("reset");
    chk32("reset_link", bus.JALRuecksprung, 32'h0);
    step();
    step();
    Reset = 1'b0;
    chk1("start_no_req", bus.Befehlsanfrage, 1'b0);
    step();
    model_pc = 32'h0;

    // ALU op with immediate handshakes
    exec_instr(T_ALU, 32'h0, 32'h0, 32'h0, 0, 0);
    // jal / jreg
    exec_instr(T_JREG, 32'h0, 32'h10, 32'h0, 0, 0);
    exec_instr(T_JAL, 32'h20, 32'h0, 32'h0, 0, 0);
    chk32("jal_target", model_pc, 32'h30);
    exec_instr(T_JREG, 32'h0, 32'h80, 32'h0, 1, 0);
    // branches
    exec_instr(T_BEZ, 32'h8, 32'h0, 32'h0, 0, 0);
    exec_instr(T_BEZ, 32'h8, 32'h0, 32'h5, 0, 0);
    exec_instr(T_BNEZ, 32'h10, 32'h0, 32'h5, 2, 0);
    exec_instr(T_BNEZ, 32'h10, 32'h0, 32'h0, 0, 0);
    // store with slow memory, then load
    exec_instr(T_STORE, 32'h0, 32'h0, 32'h0, 0, 3);
    exec_instr(T_LOAD, 32'h0, 32'h0, 32'h0, 0, 1);
    // PC wrap-around
    exec_instr(T_JREG, 32'h0, 32'hFFFF_FFFF, 32'h0, 0, 0);
    exec_instr(T_ALU, 32'h0, 32'h0, 32'h0, 0, 2);
    chk32("wrap_pc", bus.PC, 32'h0);
    exec_instr(T_J, 32'hFFFF_FFF0, 32'h0, 32'h0, 0, 0);
    exec_instr(T_BEZ, 32'h20, 32'h0, 32'h0, 0, 0);

    // Random instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [31:0] c;
      c = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      exec_instr(int'($urandom_range(0, 7)), $urandom, $urandom, c,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a load's memory wait
    bus.BefehlBereit = 1'b1;
    step();
    bus.BefehlBereit = 1'b0;
    bus.LoadBefehl   = 1'b1;
    step();
    step();
    clear_flags();
    chk1("pre_reset_mem_req", bus.SpeicherAnfrage, 1'b1);
    step();
    #2 Reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    bus.SpeicherBereit = 1'b1;
    step();
    Reset = 1'b0;
    chk1("midreset_hold_rs", bus.RegisterSchreiben, 1'b0);
    step();
    bus.SpeicherBereit = 1'b0;
    chk1("midreset_fetch", bus.Befehlsanfrage, 1'b1);
    chk1("midreset_no_rs", bus.RegisterSchreiben, 1'b0);
    chk32("midreset_pc", bus.PC, 32'h0);
    model_pc = 32'h0;
    exec_instr(T_ALU, 32'h0, 32'h0, 32'h0, 0, 0);

    // ALU never finishes: timeout after 4 wait cycles, sticky
    bus.BefehlBereit = 1'b1;
    step();
    bus.BefehlBereit = 1'b0;
    step();
    step();
    chk1("to_alu_start", bus.ALUStart, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("to_not_yet", bus.Fehler, 1'b0);
    end
    step();
    chk1("to_fehler", bus.Fehler, 1'b1);
    chk1("to_fehler_no_req", bus.Befehlsanfrage, 1'b0);
    bus.ALUFertig      = 1'b1;
    bus.BefehlBereit   = 1'b1;
    bus.SpeicherBereit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("to_sticky", bus.Fehler, 1'b1);
      chk1("to_sticky_no_rs", bus.RegisterSchreiben, 1'b0);
      chk1("to_sticky_no_req", bus.Befehlsanfrage, 1'b0);
      chk1("to_sticky_no_mem", bus.SpeicherAnfrage, 1'b0);
      chk32("to_sticky_pc", bus.PC, model_pc);
    end
    bus.ALUFertig      = 1'b0;
    bus.BefehlBereit   = 1'b0;
    bus.SpeicherBereit = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check_reset_outputs("to_reset");
    step();
    Reset = 1'b0;
    step();
    model_pc = 32'h0;
    // Fetch timeout after 4 cycles without BefehlBereit
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("fetch_to_not_yet", bus.Fehler, 1'b0);
    end
    step();
    chk1("fetch_to_fehler", bus.Fehler, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
